// File: rtl/trap_ctrl.sv
// trap_ctrl: prioritises EX exceptions and the UART irq, sequences trap entry, flush, vector and mret return
module trap_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ecall_i,
  input  logic        stack_mismatch_i,
  input  logic        mret_i,
  input  logic        uart_irq_i,
  input  logic        irq_en_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        trigger_trap_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        trapping_o,
  output logic        double_fault_o
);
  typedef enum logic [2:0] {IDLE, TAKE, DRAIN, VECTOR, HANDLER, RETURN} state_t;
  localparam logic [2:0] DRAIN_LAST = 3'(FLUSH_CYCLES == 0 ? 0 : FLUSH_CYCLES - 1);
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [2:0] cnt;
  logic exc_sm, exc_ec, irq, take;
  assign exc_sm = ex_valid_i & stack_mismatch_i;
  assign exc_ec = ex_valid_i & ecall_i;
  assign irq    = sync_q[SYNC_STAGES-1] & irq_en_i & ex_valid_i;
  assign take   = (state == IDLE) & (exc_sm | exc_ec | irq);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = take ? TAKE : IDLE;
      TAKE:    state_nx = (FLUSH_CYCLES > 0) ? DRAIN : VECTOR;
      DRAIN:   state_nx = (cnt == DRAIN_LAST) ? VECTOR : DRAIN;
      VECTOR:  state_nx = HANDLER;
      HANDLER: state_nx = (ex_valid_i & mret_i) ? RETURN : HANDLER;
      RETURN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q         <= '0;
      cnt            <= '0;
      cause_o        <= '0;
      epc_o          <= '0;
      redirect_pc_o  <= '0;
      double_fault_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_irq_i};
      cnt    <= (state == DRAIN) ? cnt + 3'd1 : 3'd0;
      if (take) begin
        cause_o <= exc_sm ? 32'h0000_0018 : exc_ec ? 32'h0000_000B : 32'h8000_000B;
        epc_o   <= ex_pc_i;
      end
      if (state_nx == VECTOR) redirect_pc_o <= {mtvec_i[31:2], 2'b00};
      if (state_nx == RETURN) redirect_pc_o <= {mepc_i[31:2], 2'b00};
      if (state == HANDLER && ex_valid_i && (ecall_i || stack_mismatch_i)) double_fault_o <= 1'b1;
    end
  assign trigger_trap_o = (state == TAKE);
  assign flush_o        = (state == TAKE) | (state == DRAIN) | (state == VECTOR) | (state == RETURN);
  assign redirect_o     = (state == VECTOR) | (state == RETURN);
  assign trapping_o     = (state == HANDLER) | (state == RETURN);
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard-driven scenario bench for trap_ctrl at default parameters
module tb_trap_ctrl;
  logic clk = 0, rst = 1;
  logic ex_valid_i = 0, ecall_i = 0, stack_mismatch_i = 0, mret_i = 0, uart_irq_i = 0, irq_en_i = 0;
  logic [31:0] ex_pc_i = 0, mtvec_i = 0, mepc_i = 0;
  logic trigger_trap_o, flush_o, redirect_o, trapping_o, double_fault_o;
  logic [31:0] cause_o, epc_o, redirect_pc_o;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] cause; logic [31:0] epc;} take_t;
  take_t take_q[$];
  logic [31:0] rpc_q[$];

  trap_ctrl dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .ecall_i(ecall_i),
    .stack_mismatch_i(stack_mismatch_i), .mret_i(mret_i), .uart_irq_i(uart_irq_i),
    .irq_en_i(irq_en_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i), .trigger_trap_o(trigger_trap_o),
    .cause_o(cause_o), .epc_o(epc_o), .flush_o(flush_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .trapping_o(trapping_o), .double_fault_o(double_fault_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    step();
    checks++;
    if ({trigger_trap_o, flush_o, redirect_o, trapping_o, double_fault_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {trigger_trap_o, flush_o, redirect_o, trapping_o, double_fault_o});
    end
    checks++;
    if ({cause_o, epc_o, redirect_pc_o} !== 96'b0) begin
      errors++; $display("FAIL reset_regs got %h %h %h want 0", cause_o, epc_o, redirect_pc_o);
    end
    rst = 0;
    step();
  endtask

  // Drives a one-cycle ecall and checks the full default-latency entry sequence
  task automatic test_ecall(input logic [31:0] pc, input logic [31:0] tvec, input logic [31:0] want_rpc);
    take_t e;
    ex_valid_i = 1; ecall_i = 1; ex_pc_i = pc; mtvec_i = tvec;
    take_q.push_back('{32'h0000_000B, pc});
    rpc_q.push_back(want_rpc);
    step();
    ex_valid_i = 0; ecall_i = 0;
    e = take_q.pop_front();
    checks++;
    if (trigger_trap_o !== 1'b1 || flush_o !== 1'b1) begin
      errors++; $display("FAIL ecall_take trig=%b flush=%b want 1 1", trigger_trap_o, flush_o);
    end
    checks++;
    if (cause_o !== e.cause || epc_o !== e.epc) begin
      errors++; $display("FAIL ecall_cause got %h/%h want %h/%h", cause_o, epc_o, e.cause, e.epc);
    end
    for (int i = 2; i <= 3; i++) begin
      step();
      checks++;
      if ({trigger_trap_o, flush_o, redirect_o, trapping_o} !== 4'b0100) begin
        errors++; $display("FAIL ecall_drain%0d got %b want 0100", i, {trigger_trap_o, flush_o, redirect_o, trapping_o});
      end
    end
    step();
    checks++;
    if ({flush_o, redirect_o, trapping_o} !== 3'b110 || redirect_pc_o !== rpc_q.pop_front()) begin
      errors++; $display("FAIL ecall_vector got f=%b r=%b t=%b pc=%h want 110 %h", flush_o, redirect_o, trapping_o, redirect_pc_o, want_rpc);
    end
    step();
    checks++;
    if ({trigger_trap_o, flush_o, redirect_o, trapping_o} !== 4'b0001) begin
      errors++; $display("FAIL ecall_handler got %b want 0001", {trigger_trap_o, flush_o, redirect_o, trapping_o});
    end
  endtask

  task automatic test_double_fault();
    ex_valid_i = 1; ecall_i = 1; ex_pc_i = 32'h180;
    step();
    ex_valid_i = 0; ecall_i = 0;
    checks++;
    if (double_fault_o !== 1'b1 || trigger_trap_o !== 1'b0 || trapping_o !== 1'b1 || flush_o !== 1'b0) begin
      errors++; $display("FAIL double_fault got df=%b trig=%b trap=%b flush=%b want 1 0 1 0", double_fault_o, trigger_trap_o, trapping_o, flush_o);
    end
  endtask

  task automatic test_return(input logic [31:0] mepc, input logic [31:0] want_rpc);
    ex_valid_i = 1; mret_i = 1; mepc_i = mepc;
    rpc_q.push_back(want_rpc);
    step();
    ex_valid_i = 0; mret_i = 0;
    checks++;
    if ({flush_o, redirect_o, trapping_o} !== 3'b111 || redirect_pc_o !== rpc_q.pop_front()) begin
      errors++; $display("FAIL return_redirect got f=%b r=%b t=%b pc=%h want 111 %h", flush_o, redirect_o, trapping_o, redirect_pc_o, want_rpc);
    end
    step();
    checks++;
    if ({trigger_trap_o, flush_o, redirect_o, trapping_o} !== 4'b0000) begin
      errors++; $display("FAIL return_idle got %b want 0000", {trigger_trap_o, flush_o, redirect_o, trapping_o});
    end
  endtask

  task automatic test_ignored_mret();
    int bad = 0;
    ex_valid_i = 1; mret_i = 1; mepc_i = 32'h0000_0900;
    for (int i = 0; i < 4; i++) begin
      step();
      if ({trigger_trap_o, flush_o, redirect_o, trapping_o} !== 4'b0) bad++;
    end
    ex_valid_i = 0; mret_i = 0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL idle_mret got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_priority();
    take_t e;
    int pulses = 0;
    uart_irq_i = 1; irq_en_i = 0; mtvec_i = 32'h0000_0404;
    repeat (4) step();
    irq_en_i = 1; ex_valid_i = 1; ecall_i = 1; stack_mismatch_i = 1; ex_pc_i = 32'h200;
    take_q.push_back('{32'h0000_0018, 32'h200});
    rpc_q.push_back(32'h404);
    step();
    ex_valid_i = 0; ecall_i = 0; stack_mismatch_i = 0;
    e = take_q.pop_front();
    checks++;
    if (trigger_trap_o !== 1'b1 || cause_o !== e.cause || epc_o !== e.epc) begin
      errors++; $display("FAIL prio_cause got trig=%b %h/%h want 1 %h/%h", trigger_trap_o, cause_o, epc_o, e.cause, e.epc);
    end
    pulses = 1;
    for (int i = 0; i < 10 && trapping_o !== 1'b1; i++) begin
      step();
      if (trigger_trap_o === 1'b1) pulses++;
      if (redirect_o === 1'b1) begin
        checks++;
        if (redirect_pc_o !== rpc_q.pop_front()) begin
          errors++; $display("FAIL prio_vector got %h want 404", redirect_pc_o);
        end
      end
    end
    checks++;
    if (trapping_o !== 1'b1 || pulses != 1) begin
      errors++; $display("FAIL prio_single got trap=%b pulses=%0d want 1 1", trapping_o, pulses);
    end
    uart_irq_i = 0; irq_en_i = 0;
  endtask

  task automatic test_irq_gating();
    take_t e;
    int bad = 0;
    uart_irq_i = 1; irq_en_i = 0; ex_valid_i = 1; ex_pc_i = 32'h300; mtvec_i = 32'h0000_0500;
    for (int i = 0; i < 5; i++) begin step(); if (trigger_trap_o !== 1'b0) bad++; end
    irq_en_i = 1; ex_valid_i = 0;
    for (int i = 0; i < 3; i++) begin step(); if (trigger_trap_o !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL irq_gated got %0d pulses want 0", bad);
    end
    ex_valid_i = 1;
    take_q.push_back('{32'h8000_000B, 32'h300});
    step();
    ex_valid_i = 0;
    e = take_q.pop_front();
    checks++;
    if (trigger_trap_o !== 1'b1 || cause_o !== e.cause || epc_o !== e.epc) begin
      errors++; $display("FAIL irq_take got trig=%b %h/%h want 1 %h/%h", trigger_trap_o, cause_o, epc_o, e.cause, e.epc);
    end
    for (int i = 0; i < 10 && trapping_o !== 1'b1; i++) step();
    checks++;
    if (trapping_o !== 1'b1 || redirect_pc_o !== 32'h500) begin
      errors++; $display("FAIL irq_handler got trap=%b pc=%h want 1 500", trapping_o, redirect_pc_o);
    end
    // irq stays asserted through mret and must be re-taken at the first valid IDLE edge
    test_return(32'h0000_0302, 32'h300);
    ex_valid_i = 1; ex_pc_i = 32'h400;
    take_q.push_back('{32'h8000_000B, 32'h400});
    step();
    ex_valid_i = 0; uart_irq_i = 0; irq_en_i = 0;
    e = take_q.pop_front();
    checks++;
    if (trigger_trap_o !== 1'b1 || cause_o !== e.cause || epc_o !== e.epc) begin
      errors++; $display("FAIL irq_retake got trig=%b %h/%h want 1 %h/%h", trigger_trap_o, cause_o, epc_o, e.cause, e.epc);
    end
    for (int i = 0; i < 10 && trapping_o !== 1'b1; i++) step();
    test_return(32'h0000_0400, 32'h400);
  endtask

  task automatic test_reset_mid_drain();
    ex_valid_i = 1; ecall_i = 1; ex_pc_i = 32'h600;
    step();
    ex_valid_i = 0; ecall_i = 0;
    step();
    checks++;
    if (flush_o !== 1'b1 || trigger_trap_o !== 1'b0) begin
      errors++; $display("FAIL drain_before_reset got flush=%b trig=%b want 1 0", flush_o, trigger_trap_o);
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({trigger_trap_o, flush_o, redirect_o, trapping_o, double_fault_o} !== 5'b0 || {cause_o, epc_o, redirect_pc_o} !== 96'b0) begin
      errors++; $display("FAIL async_reset got %b %h %h %h want all 0", {trigger_trap_o, flush_o, redirect_o, trapping_o, double_fault_o}, cause_o, epc_o, redirect_pc_o);
    end
    take_q.delete(); rpc_q.delete();
    step();
    rst = 0;
    step();
    test_ecall(32'h0000_0700, 32'h0000_020B, 32'h208);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ecall(32'h0000_0100, 32'h0000_0204, 32'h204);
    test_double_fault();
    test_return(32'h0000_0103, 32'h100);
    checks++;
    if (double_fault_o !== 1'b1) begin
      errors++; $display("FAIL df_sticky got %b want 1", double_fault_o);
    end
    test_ignored_mret();
    test_priority();
    test_return(32'h0000_0200, 32'h200);
    test_irq_gating();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
